fpu_norm_pipe: RTL and testbench

Pipelined, parametrised normalisation stage for the FPU add/sub datapath. It sits between the mantissa adder and the result packer. It takes the raw adder sum (with carry-out), finds the leading one internally, shifts, adjusts the exponent and flags zero, exponent overflow and exponent underflow. A two-stage valid/ready pipeline gives back-pressure to the FFT butterfly datapath.

---
 rtl/fpu_norm_pipe.sv | 167 ++++++++++++++++
 tb/tb_fpu_norm_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_norm_pipe.sv
// rtl/fpu_norm_pipe.sv - two-stage FP add/sub normalisation pipe; FPU_NORM_ROUND_EN enables RNE rounding in S2
module fpu_norm_pipe #(
  parameter int SIZE_MAN  = 28,
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_LOPD = $clog2(SIZE_MAN)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_sign,
  input  logic [SIZE_EXP-1:0] i_exponent,
  input  logic [SIZE_MAN:0]   i_mantissa,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_sign,
  output logic [SIZE_EXP-1:0] o_exponent,
  output logic [SIZE_MAN-1:0] o_mantissa,
  output logic                o_zero,
  output logic                o_exp_overflow,
  output logic                o_exp_underflow
);

  localparam logic [SIZE_EXP:0] EXP_MAX = {1'b0, {SIZE_EXP{1'b1}}};
  localparam logic [SIZE_EXP:0] EXP_ONE = (SIZE_EXP+1)'(1);

  logic adv1, adv2;

  logic                 s1_valid_q, s1_sign_q, s1_carry_q, s1_zero_q;
  logic [SIZE_EXP-1:0]  s1_exp_q;
  logic [SIZE_MAN:0]    s1_man_q;
  logic [SIZE_LOPD-1:0] s1_k_q;

  logic                 s2_valid_q, s2_sign_q, s2_zero_q, s2_ovf_q, s2_unf_q;
  logic [SIZE_EXP-1:0]  s2_exp_q;
  logic [SIZE_MAN-1:0]  s2_man_q;

  logic                 in_zero;
  logic [SIZE_LOPD-1:0] in_k;

  assign adv2    = ~s2_valid_q | i_ready;
  assign adv1    = ~s1_valid_q | adv2;
  assign o_ready = adv1;

  // Ascending scan: the highest set bit below the carry wins.
  always_comb begin
    in_zero = (i_mantissa == '0);
    in_k    = '0;
    for (int i = 0; i < SIZE_MAN; i++) begin
      if (i_mantissa[i]) in_k = SIZE_LOPD'(SIZE_MAN - 1 - i);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_carry_q <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_man_q   <= '0;
      s1_k_q     <= '0;
    end else if (adv1) begin
      s1_valid_q <= i_valid;
      if (i_valid) begin
        s1_sign_q  <= i_sign;
        s1_carry_q <= i_mantissa[SIZE_MAN];
        s1_zero_q  <= in_zero;
        s1_exp_q   <= i_exponent;
        s1_man_q   <= i_mantissa;
        s1_k_q     <= in_k;
      end
    end
  end

  logic [SIZE_EXP:0]   e_ext, k_ext, exp_d;
  logic [SIZE_MAN-1:0] man_d;
  logic                sign_d, zero_d, ovf_d, unf_d, inc_d;
`ifdef FPU_NORM_ROUND_EN
  logic                round_up;
  logic [SIZE_MAN-3:0] rnd;
`endif

  always_comb begin
    e_ext  = {1'b0, s1_exp_q};
    k_ext  = (SIZE_EXP+1)'(s1_k_q);
    sign_d = s1_sign_q;
    zero_d = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    inc_d  = 1'b0;
    man_d  = s1_man_q[SIZE_MAN-1:0];
    exp_d  = e_ext;
`ifdef FPU_NORM_ROUND_EN
    round_up = 1'b0;
    rnd      = '0;
`endif
    if (s1_zero_q) begin
      sign_d = 1'b0;
      zero_d = 1'b1;
      man_d  = '0;
      exp_d  = '0;
    end else if (s1_carry_q) begin
      man_d = s1_man_q[SIZE_MAN:1] | {{(SIZE_MAN-1){1'b0}}, s1_man_q[0]};
      exp_d = e_ext + EXP_ONE;
      inc_d = 1'b1;
    end else if (k_ext != '0) begin
      if (k_ext < e_ext) begin
        man_d = s1_man_q[SIZE_MAN-1:0] << s1_k_q;
        exp_d = e_ext - k_ext;
      end else begin
        sign_d = 1'b0;
        unf_d  = 1'b1;
        man_d  = '0;
        exp_d  = '0;
      end
    end
`ifdef FPU_NORM_ROUND_EN
    // Flagged results carry a zero mantissa, so round_up stays 0 for them.
    round_up = man_d[2] & (man_d[3] | man_d[1] | man_d[0]);
    rnd      = {1'b0, man_d[SIZE_MAN-1:3]} + (SIZE_MAN-2)'(round_up);
    if (rnd[SIZE_MAN-3]) begin
      man_d = {1'b1, {(SIZE_MAN-1){1'b0}}};
      exp_d = exp_d + EXP_ONE;
      inc_d = 1'b1;
    end else begin
      man_d = {rnd[SIZE_MAN-4:0], 3'b000};
    end
`endif
    if (inc_d && (exp_d >= EXP_MAX)) begin
      ovf_d = 1'b1;
      exp_d = EXP_MAX;
      man_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_unf_q   <= 1'b0;
      s2_exp_q   <= '0;
      s2_man_q   <= '0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_q <= sign_d;
        s2_zero_q <= zero_d;
        s2_ovf_q  <= ovf_d;
        s2_unf_q  <= unf_d;
        s2_exp_q  <= exp_d[SIZE_EXP-1:0];
        s2_man_q  <= man_d;
      end
    end
  end

  assign o_valid         = s2_valid_q;
  assign o_sign          = s2_sign_q;
  assign o_exponent      = s2_exp_q;
  assign o_mantissa      = s2_man_q;
  assign o_zero          = s2_zero_q;
  assign o_exp_overflow  = s2_ovf_q;
  assign o_exp_underflow = s2_unf_q;

endmodule

// File: tb/tb_fpu_norm_pipe.sv
// tb/tb_fpu_norm_pipe.sv - self-checking bench for fpu_norm_pipe with a behavioural reference model
module tb_fpu_norm_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_sign = 1'b0;
  logic [7:0]  i_exponent = '0;
  logic [28:0] i_mantissa = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic        o_sign;
  logic [7:0]  o_exponent;
  logic [27:0] o_mantissa;
  logic        o_zero, o_exp_overflow, o_exp_underflow;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int emitted = 0;
  bit rand_ready = 1'b0;

  logic [39:0] exp_q[$];
  logic [39:0] held;
  bit          have_hold = 1'b0;

  fpu_norm_pipe dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_exponent(i_exponent), .i_mantissa(i_mantissa),
    .o_valid(o_valid), .i_ready(i_ready), .o_sign(o_sign), .o_exponent(o_exponent),
    .o_mantissa(o_mantissa), .o_zero(o_zero), .o_exp_overflow(o_exp_overflow),
    .o_exp_underflow(o_exp_underflow)
  );

  always #5 i_clk = ~i_clk;

  // Packed as {sign, exponent, mantissa, zero, overflow, underflow}.
  function automatic logic [39:0] pack_out();
    return {o_sign, o_exponent, o_mantissa, o_zero, o_exp_overflow, o_exp_underflow};
  endfunction

  function automatic logic [39:0] model(input logic s, input logic [7:0] e, input logic [28:0] m);
    longint man;
    int ex, k;
    if (m == 0) return {1'b0, 8'h00, 28'h0, 3'b100};
    if (m[28]) begin
      man = longint'(m >> 1) | longint'(m[0]);
      ex  = int'(e) + 1;
    end else begin
      k = 0;
      while (m[27-k] == 1'b0) k++;
      if (k != 0 && k >= int'(e)) return {1'b0, 8'h00, 28'h0, 3'b001};
      man = longint'(m) << k;
      ex  = int'(e) - k;
    end
`ifdef FPU_NORM_ROUND_EN
    if ((man % 8) > 4 || ((man % 8) == 4 && ((man / 8) % 2) == 1)) man = (man / 8 + 1) * 8;
    else man = (man / 8) * 8;
    if (man >= (longint'(1) << 28)) begin
      man = longint'(1) << 27;
      ex++;
    end
`endif
    if (ex >= 255) return {s, 8'hFF, 28'h0, 3'b010};
    return {s, 8'(ex), 28'(man), 3'b000};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: compares every presented beat, checks stall stability, records accepts.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      exp_q.delete();
      have_hold = 1'b0;
    end else begin
      if (have_hold) chk("stall_hold", pack_out(), held);
      if (o_valid) begin
        if (exp_q.size() == 0) chk("spurious_beat", 1, 0);
        else begin
          chk("beat", pack_out(), exp_q[0]);
          if (i_ready) begin
            void'(exp_q.pop_front());
            emitted++;
          end
        end
      end
      have_hold = o_valid && !i_ready;
      held = pack_out();
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_sign, i_exponent, i_mantissa));
        accepted++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [28:0] m);
    int n;
    bit rdy, ok;
    i_valid = 1'b1; i_sign = s; i_exponent = e; i_mantissa = m;
    n = 0; ok = 1'b0;
    while (!ok && n < 60) begin
      @(negedge i_clk);
      rdy = o_ready;
      @(posedge i_clk);
      #1;
      n++;
      ok = rdy;
    end
    i_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic directed(input string name, input logic s, input logic [7:0] e,
                          input logic [28:0] m, input logic [39:0] req);
    int n;
    send(s, e, m);
    n = 1;
    while (!o_valid && n < 10) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'd2);
    chk(name, pack_out(), req);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  logic [28:0] rm;
  logic [7:0]  re;
  int          sel, base;

  initial begin
    // Model pinned against hand-derived values.
    chk("model_carry", model(1'b0, 8'h80, 29'h1000_0000), {1'b0, 8'h81, 28'h800_0000, 3'b000});
    chk("model_shift", model(1'b0, 8'h80, 29'h000_0100), {1'b0, 8'h6D, 28'h800_0000, 3'b000});
    chk("model_zero",  model(1'b1, 8'h45, 29'h0),        {1'b0, 8'h00, 28'h0, 3'b100});
    chk("model_unf",   model(1'b0, 8'h10, 29'h000_0100), {1'b0, 8'h00, 28'h0, 3'b001});
    chk("model_ovf",   model(1'b0, 8'hFE, 29'h1000_0000), {1'b0, 8'hFF, 28'h0, 3'b010});
    chk("model_sticky", model(1'b1, 8'h20, 29'h1000_0003), {1'b1, 8'h21, 28'h800_0001, 3'b000});

    idle(2);
    chk("reset_outputs", {o_valid, pack_out()}, 41'h0);
    chk("reset_ready", o_ready, 1);
    i_rst_n = 1'b1;
    idle(1);

    directed("carry", 1'b0, 8'h80, 29'h1000_0000, {1'b0, 8'h81, 28'h800_0000, 3'b000});
    directed("lshift", 1'b0, 8'h80, 29'h000_0100, {1'b0, 8'h6D, 28'h800_0000, 3'b000});
    directed("zero", 1'b1, 8'h45, 29'h0, {1'b0, 8'h00, 28'h0, 3'b100});
    directed("underflow", 1'b0, 8'h10, 29'h000_0100, {1'b0, 8'h00, 28'h0, 3'b001});
    directed("overflow", 1'b0, 8'hFE, 29'h1000_0000, {1'b0, 8'hFF, 28'h0, 3'b010});
`ifdef FPU_NORM_ROUND_EN
    directed("round", 1'b0, 8'h80, 29'h0FFF_FFFC, {1'b0, 8'h81, 28'h800_0000, 3'b000});
`else
    directed("round", 1'b0, 8'h80, 29'h0FFF_FFFC, {1'b0, 8'h80, 28'hFFF_FFFC, 3'b000});
`endif

    // Back-pressure: 4 beats against a 6-cycle stall.
    i_ready = 1'b0;
    base = accepted;
    fork
      begin
        send(1'b0, 8'h70, 29'h0000_1234);
        send(1'b1, 8'h90, 29'h1ABC_DEF1);
        send(1'b0, 8'h33, 29'h0800_0000);
        send(1'b1, 8'h05, 29'h0000_0001);
      end
    join_none
    idle(6);
    chk("bp_accepts", 64'(accepted - base), 64'd2);
    chk("bp_ready_low", o_ready, 0);
    base = emitted;
    i_ready = 1'b1;
    for (int c = 0; c < 30 && emitted - base < 4; c++) idle(1);
    chk("bp_emitted", 64'(emitted - base), 64'd4);
    idle(2);

    // Reset in the middle of a stall.
    i_ready = 1'b0;
    fork
      begin
        send(1'b0, 8'h40, 29'h0040_0000);
        send(1'b1, 8'h41, 29'h1000_0001);
      end
    join_none
    idle(4);
    i_rst_n = 1'b0;
    idle(1);
    chk("rst_mid_valid", o_valid, 0);
    chk("rst_mid_ready", o_ready, 1);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    idle(5);
    chk("rst_nothing_after", o_valid, 0);

    // Randomised traffic with random back-pressure.
    rand_ready = 1'b1;
    for (int b = 0; b < 400; b++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) rm = 29'h0;
      else if (sel <= 3) rm = {1'b1, 28'($urandom)};
      else rm = {1'b0, 28'($urandom) >> $urandom_range(0, 27)};
      sel = $urandom_range(0, 9);
      if (sel <= 2) re = 8'($urandom_range(1, 30));
      else if (sel == 3) re = 8'($urandom_range(250, 254));
      else re = 8'($urandom_range(1, 254));
      send(1'($urandom), re, rm);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_ready = 1'b0;
    #2;
    i_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) idle(1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("all_emitted", 64'(emitted), 64'(accepted - 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
